mem_arbiter: RTL and testbench

Parametrised multi-port memory front end. It arbitrates between NUM_PORTS requesters, such as instruction fetch, load/store and a future debug or DMA port, and drives the single byte-wide RAM bus. Each access is serialised into 1–4 byte transfers with little-endian assembly and disassembly. The block sits between the core's fetch/LSU units and the external RAM. It replaces the fixed two-client counter sequencer with a round-robin, handshaked, latency-configurable engine.

---
 rtl/mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : round-robin multi-port front end that serialises 1-4 byte accesses
//           onto a byte-wide RAM bus, with little-endian assembly and disassembly.
// Latency : accept at T -> bytes on the bus T+1..T+len; rsp at T+len+1 for
//           writes, T+len+MEM_LATENCY+1 for reads; each rdy_in-low cycle adds one.
// Backpres: requesters hold req_valid_in until the one-hot req_ready_out pulse;
//           rdy_in low freezes every register and masks all strobes and pulses.
//
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (global enable)
//   req_valid_in/req_wr_in/req_len_in/req_addr_in/req_wdata_in : per-port request
//   req_ready_out : one-hot accept, rsp_valid_out : one-hot completion
//   rsp_data_out  : read data (zero-extended, 0 for writes)
//   busy_out      : high outside IDLE
//   mem_a_out/mem_d_out/mem_wr_out : registered RAM bus, mem_d_in : RAM read byte
//
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// arbitration; left undefined the arbiter is round-robin.

module mem_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [NUM_PORTS-1:0]      req_valid_in,
    input  logic [NUM_PORTS-1:0]      req_wr_in,
    input  logic [3*NUM_PORTS-1:0]    req_len_in,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr_in,
    input  logic [32*NUM_PORTS-1:0]   req_wdata_in,
    output logic [NUM_PORTS-1:0]      req_ready_out,
    output logic [NUM_PORTS-1:0]      rsp_valid_out,
    output logic [31:0]               rsp_data_out,
    output logic                      busy_out,
    output logic [ADDR_W-1:0]         mem_a_out,
    output logic [7:0]                mem_d_out,
    output logic                      mem_wr_out,
    input  logic [7:0]                mem_d_in
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Captured request
    logic                 r_wr;
    logic [2:0]           r_len;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_wdata;
    logic [PW-1:0]        r_port;

    // r_icnt: bytes issued so far; r_ccnt: read bytes captured so far
    logic [2:0]           r_icnt;
    logic [1:0]           r_ccnt;
    logic [31:0]          r_asm;

    // One flag per issued read address, aged one stage per enabled cycle.
    // A flag reaching stage MEM_LATENCY means mem_d_in holds that byte now.
    logic [MEM_LATENCY:0] r_pipe;

    // Registered outputs
    logic [NUM_PORTS-1:0] r_rsp_vld;
    logic [31:0]          r_rsp_data;
    logic [ADDR_W-1:0]    r_mem_a;
    logic [7:0]           r_mem_d;
    logic                 r_mem_wr;

    // Arbitration and selection
    logic [NUM_PORTS-1:0] w_pri_vec;
    logic [PW-1:0]        w_gnt_idx;
    logic [NUM_PORTS-1:0] w_gnt_oh;
    logic [NUM_PORTS-1:0] w_port_oh;
    logic                 w_any_req;
    logic                 w_accept;
    logic                 w_sel_wr;
    logic [2:0]           w_sel_len_raw;
    logic [2:0]           w_sel_len;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [31:0]          w_sel_wdata;

    logic                 w_rd_more;
    logic                 w_issue_rd;
    logic                 w_cap;
    logic                 w_last_cap;
    logic                 w_wr_done;
    logic [31:0]          w_asm_nxt;

    assign w_any_req = |req_valid_in;
    assign w_accept  = rdy_in && (r_state == S_IDLE) && w_any_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Lowest index always wins; no rotation state.
    assign w_pri_vec = req_valid_in;
`else
    logic [PW-1:0]        r_ptr;
    logic [NUM_PORTS-1:0] w_req_hi;

    // Ports at or above the pointer take precedence; if none of them is
    // requesting, fall back to the lowest requesting port (the wrap-around).
    always_comb begin
        w_req_hi = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_req_hi[i] = req_valid_in[i] && (PW'(i) >= r_ptr);
        end
        w_pri_vec = (|w_req_hi) ? w_req_hi : req_valid_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end
`endif

    // Lowest set bit of the priority vector is the winner.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_pri_vec[i]) begin
                w_gnt_idx = PW'(i);
            end
        end
    end

    // Request mux and one-hot decodes with constant indices only.
    always_comb begin
        w_gnt_oh      = '0;
        w_port_oh     = '0;
        w_sel_wr      = 1'b0;
        w_sel_len_raw = 3'd0;
        w_sel_addr    = '0;
        w_sel_wdata   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_gnt_oh[i]   = 1'b1;
                w_sel_wr      = req_wr_in[i];
                w_sel_len_raw = req_len_in[3*i +: 3];
                w_sel_addr    = req_addr_in[ADDR_W*i +: ADDR_W];
                w_sel_wdata   = req_wdata_in[32*i +: 32];
            end
            if (r_port == PW'(i)) begin
                w_port_oh[i] = 1'b1;
            end
        end
    end

    // Out-of-range lengths (0, 5..7) mean a full word.
    assign w_sel_len = ((w_sel_len_raw == 3'd0) || (w_sel_len_raw > 3'd4)) ? 3'd4 : w_sel_len_raw;

    assign w_rd_more  = (r_state == S_READ) && (r_icnt < r_len);
    assign w_issue_rd = (w_accept && !w_sel_wr) || w_rd_more;
    assign w_cap      = (r_state == S_READ) && r_pipe[MEM_LATENCY];
    assign w_last_cap = w_cap && ({1'b0, r_ccnt} == (r_len - 3'd1));
    assign w_wr_done  = (r_state == S_WRITE) && (r_icnt >= r_len);

    // Incoming byte merged into its little-endian lane.
    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[{r_ccnt, 3'b000} +: 8] = mem_d_in;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (rdy_in) begin
            case (r_state)
                S_IDLE:  if (w_any_req)  w_state_nxt = w_sel_wr ? S_WRITE : S_READ;
                S_READ:  if (w_last_cap) w_state_nxt = S_RESP;
                S_WRITE: if (w_wr_done)  w_state_nxt = S_RESP;
                S_RESP:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready_out = '0;
        if (w_accept) begin
            req_ready_out = w_gnt_oh;
        end
        rsp_valid_out = rdy_in ? r_rsp_vld : '0;
        mem_wr_out    = r_mem_wr & rdy_in;
        busy_out      = (r_state != S_IDLE);
    end

    assign rsp_data_out = r_rsp_data;
    assign mem_a_out    = r_mem_a;
    assign mem_d_out    = r_mem_d;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr       <= 1'b0;
            r_len      <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_port     <= '0;
            r_icnt     <= 3'd0;
            r_ccnt     <= 2'd0;
            r_asm      <= '0;
            r_pipe     <= '0;
            r_rsp_vld  <= '0;
            r_rsp_data <= '0;
            r_mem_a    <= '0;
            r_mem_d    <= '0;
            r_mem_wr   <= 1'b0;
        end else if (rdy_in) begin
            r_pipe <= {r_pipe[MEM_LATENCY-1:0], w_issue_rd};
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr    <= w_sel_wr;
                        r_len   <= w_sel_len;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_port  <= w_gnt_idx;
                        r_icnt  <= 3'd1;
                        r_ccnt  <= 2'd0;
                        r_asm   <= '0;
                        // Byte 0 goes out on the accept edge itself.
                        r_mem_a  <= w_sel_addr;
                        r_mem_wr <= w_sel_wr;
                        if (w_sel_wr) begin
                            r_mem_d <= w_sel_wdata[7:0];
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_more) begin
                        r_mem_a <= r_addr + ADDR_W'(r_icnt);
                        r_icnt  <= r_icnt + 3'd1;
                    end
                    if (w_cap) begin
                        r_asm  <= w_asm_nxt;
                        r_ccnt <= r_ccnt + 2'd1;
                    end
                    if (w_last_cap) begin
                        r_rsp_vld  <= w_port_oh;
                        r_rsp_data <= w_asm_nxt;
                    end
                end
                S_WRITE: begin
                    if (!w_wr_done) begin
                        r_mem_a <= r_addr + ADDR_W'(r_icnt);
                        r_mem_d <= r_wdata[{r_icnt[1:0], 3'b000} +: 8];
                        r_icnt  <= r_icnt + 3'd1;
                    end else begin
                        r_mem_wr   <= 1'b0;
                        r_rsp_vld  <= w_port_oh;
                        r_rsp_data <= '0;
                    end
                end
                S_RESP: begin
                    r_rsp_vld <= '0;
                end
                default: begin
                    r_rsp_vld <= '0;
                end
            endcase
        end
    end

    // r_wr is kept for debug visibility of the captured request type.
    logic w_unused;
    assign w_unused = r_wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter with a byte RAM model and a
//           transaction-level expectation model (grant order, bus bytes, timing).
// Latency : expectations derived from accept time, length and stall cycles.
// Backpres: drives rdy_in stalls and competing requests; all waits are bounded.

module tb_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int ML = 1;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic [NP-1:0]   req_valid_in;
    logic [NP-1:0]   req_wr_in;
    logic [3*NP-1:0] req_len_in;
    logic [AW*NP-1:0] req_addr_in;
    logic [32*NP-1:0] req_wdata_in;
    logic [NP-1:0]   req_ready_out;
    logic [NP-1:0]   rsp_valid_out;
    logic [31:0]     rsp_data_out;
    logic            busy_out;
    logic [AW-1:0]   mem_a_out;
    logic [7:0]      mem_d_out;
    logic            mem_wr_out;
    logic [7:0]      mem_d_in;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .MEM_LATENCY (ML)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .req_valid_in  (req_valid_in),
        .req_wr_in     (req_wr_in),
        .req_len_in    (req_len_in),
        .req_addr_in   (req_addr_in),
        .req_wdata_in  (req_wdata_in),
        .req_ready_out (req_ready_out),
        .rsp_valid_out (rsp_valid_out),
        .rsp_data_out  (rsp_data_out),
        .busy_out      (busy_out),
        .mem_a_out     (mem_a_out),
        .mem_d_out     (mem_d_out),
        .mem_wr_out    (mem_wr_out),
        .mem_d_in      (mem_d_in)
    );

    // ---------------- RAM model ----------------
    logic [7:0] ram [logic [31:0]];
    logic [7:0] dpipe [ML] = '{default: 8'h00};

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    // Data for the address shown in cycle C appears in cycle C+ML; held while stalled.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr_out) ram[mem_a_out] = mem_d_out;
            dpipe[0] <= rd(mem_a_out);
            for (int i = 1; i < ML; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign mem_d_in = dpipe[ML-1];

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int model_ptr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner(input logic [NP-1:0] m);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NP; i++) if (m[i]) return i;
`else
        for (int i = 0; i < NP; i++) if (m[(model_ptr + i) % NP]) return (model_ptr + i) % NP;
`endif
        return 0;
    endfunction

    // Per-port request parameters
    logic        p_wr   [NP];
    logic [2:0]  p_len  [NP];
    logic [31:0] p_addr [NP];
    logic [31:0] p_wd   [NP];

    // Called at a negedge of an idle cycle. rdy_in is low in relative cycles s..s+n-1.
    task automatic do_txn(input logic [NP-1:0] mask, input int s, input int n,
                          output int rk, output logic [31:0] rdata, output int w);
        int len, lat, a, k;
        logic [31:0] exp_d, exp_a;
        logic [NP-1:0] oh;
        bit done;
        for (int p = 0; p < NP; p++) begin
            req_wr_in[p]            = p_wr[p];
            req_len_in[3*p +: 3]    = p_len[p];
            req_addr_in[32*p +: 32] = p_addr[p];
            req_wdata_in[32*p +: 32] = p_wd[p];
        end
        req_valid_in = mask;
        rdy_in = 1'b1;
        #1;
        w  = exp_winner(mask);
        oh = NP'(1) << w;
        chk("grant", req_ready_out, oh);
        chk("idle_busy", busy_out, 0);
        len = (p_len[w] == 0 || p_len[w] > 4) ? 4 : int'(p_len[w]);
        lat = p_wr[w] ? len : len + ML;
        exp_d = '0;
        if (!p_wr[w]) for (int i = 0; i < len; i++) exp_d[8*i +: 8] = rd(p_addr[w] + 32'(i));
`ifndef MEM_ARB_FIXED_PRIO_EN
        model_ptr = (w + 1) % NP;
`endif
        @(posedge clk_in);
        a = 1; k = 1; done = 0; rk = -1; rdata = '0;
        while (!done && k < 60) begin
            @(negedge clk_in);
            if (k == 1) req_valid_in[w] = 1'b0;
            rdy_in = !(k >= s && k < s + n);
            #1;
            exp_a = p_addr[w] + 32'(((a < len) ? a : len) - 1);
            chk("mem_a", mem_a_out, exp_a);
            chk("mem_wr", mem_wr_out, p_wr[w] && a <= len && rdy_in);
            if (p_wr[w] && a <= len) chk("mem_d", mem_d_out, p_wd[w][8*(a-1) +: 8]);
            chk("busy", busy_out, 1);
            chk("no_accept_busy", req_ready_out, 0);
            chk("rsp_valid", rsp_valid_out, (a == lat + 1 && rdy_in) ? oh : '0);
            if (a == lat + 1 && rdy_in) begin
                chk("rsp_data", rsp_data_out, exp_d);
                done  = 1;
                rk    = k;
                rdata = rsp_data_out;
            end
            @(posedge clk_in);
            if (rdy_in) a++;
            k++;
        end
        chk("rsp_seen", done, 1);
        @(negedge clk_in);
        rdy_in = 1'b1;
        #1;
        chk("back_idle", busy_out, 0);
        chk("rsp_cleared", rsp_valid_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        int rk, w, s, n;
        logic [31:0] rdv;
        logic [NP-1:0] m;

        req_valid_in = '0; req_wr_in = '0; req_len_in = '0;
        req_addr_in = '0; req_wdata_in = '0;
        rdy_in = 1'b0; rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_mem_a", mem_a_out, 0);
        chk("rst_mem_d", mem_d_out, 0);
        chk("rst_mem_wr", mem_wr_out, 0);
        chk("rst_rsp_valid", rsp_valid_out, 0);
        chk("rst_rsp_data", rsp_data_out, 0);
        rst_in = 1'b1; rdy_in = 1'b1;
        @(negedge clk_in);

        // Reset in the middle of a 4-byte read from port 0
        req_wr_in = '0; req_len_in[2:0] = 3'd4; req_addr_in[31:0] = 32'h40;
        req_valid_in = 2'b01;
        #1;
        chk("pre_rst_grant", req_ready_out, 2'b01);
        @(negedge clk_in);
        req_valid_in = '0;
        @(negedge clk_in);
        #1;
        chk("mid_read_busy", busy_out, 1);
        rst_in = 1'b0;
        #1;
        chk("abort_busy", busy_out, 0);
        chk("abort_mem_a", mem_a_out, 0);
        chk("abort_mem_wr", mem_wr_out, 0);
        chk("abort_rsp_data", rsp_data_out, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            #1;
            chk("abort_no_rsp", rsp_valid_out, 0);
            chk("abort_idle", busy_out, 0);
        end

        // First grant after reset goes to port 0 even with both requesting
        for (int p = 0; p < NP; p++) begin
            p_wr[p] = 1'b0; p_len[p] = 3'd1; p_addr[p] = 32'h200 + 32'(p); p_wd[p] = '0;
        end
        do_txn(2'b11, 100, 0, rk, rdv, w);

        // Port 1 reads a word at 0x100
        p_wr[1] = 1'b0; p_len[1] = 3'd4; p_addr[1] = 32'h100;
        do_txn(2'b10, 100, 0, rk, rdv, w);
        chk("rdword_data", rdv, 32'h44332211);
        chk("rdword_latency", rk, 6);

        // Port 0 writes a half word across a 0x300 boundary
        p_wr[0] = 1'b1; p_len[0] = 3'd2; p_addr[0] = 32'h2FF; p_wd[0] = 32'hAABBCCDD;
        do_txn(2'b01, 100, 0, rk, rdv, w);
        chk("wrhalf_latency", rk, 3);
        chk("wrhalf_data", rdv, 0);

        // Both ports request continuously
        for (int p = 0; p < NP; p++) begin
            p_wr[p] = 1'b0; p_len[p] = 3'd1; p_addr[p] = 32'h500 + 32'(p);
        end
        for (int i = 0; i < 4; i++) do_txn(2'b11, 100, 0, rk, rdv, w);

        // Three stall cycles during byte 1 of a 4-byte read
        p_wr[0] = 1'b0; p_len[0] = 3'd4; p_addr[0] = 32'h100;
        do_txn(2'b01, 2, 3, rk, rdv, w);
        chk("stall_latency", rk, 9);
        chk("stall_data", rdv, 32'h44332211);

        // Length 0 clamps to 4 and the address wraps
        p_wr[0] = 1'b0; p_len[0] = 3'd0; p_addr[0] = 32'hFFFF_FFFE;
        do_txn(2'b01, 100, 0, rk, rdv, w);
        chk("wrap_latency", rk, 6);

        // Randomised traffic
        for (int t = 0; t < 40; t++) begin
            m = NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) begin
                p_wr[p]   = 1'($urandom_range(0, 1));
                p_len[p]  = 3'($urandom_range(0, 7));
                p_addr[p] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                        : 32'($urandom_range(0, 255));
                p_wd[p]   = $urandom;
            end
            s = $urandom_range(1, 8);
            n = $urandom_range(0, 2);
            do_txn(m, s, n, rk, rdv, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
